// File: rtl/reflet_float_div_div_pkg.sv
// Shared definitions for the iterative mantissa divider: FSM encoding and iteration count helper.
package reflet_float_div_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // Number of RUN cycles needed to produce a 2*size-bit quotient at the given bits per cycle.
    function automatic int div_iters(input int size, input int bits_per_cycle);
        return (2 * size) / bits_per_cycle;
    endfunction

endpackage

// File: rtl/reflet_float_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module reflet_float_div_step #(
    parameter int size = 10
) (
    input  logic [size:0]   i_rem,
    input  logic            i_bit,
    input  logic [size-1:0] i_div,
    output logic [size:0]   o_rem,
    output logic            o_q
);

    logic [size+1:0] w_sh;
    logic [size+1:0] w_div_ext;

    assign w_sh      = {i_rem, i_bit};
    assign w_div_ext = {2'b00, i_div};
    assign o_q       = (w_sh >= w_div_ext);
    // The remainder stays below the divisor, so the top bit of the shifted value is always zero.
    assign o_rem     = o_q ? (size+1)'(w_sh - w_div_ext) : (size+1)'(w_sh);

endmodule

// File: rtl/reflet_float_div_div.sv
// Restoring mantissa divider: quot = (in1 << size) / in2, one quotient bit per cycle,
// or two per cycle when REFLET_FLOAT_DIV_RADIX4_EN is defined.
module reflet_float_div_div
    import reflet_float_div_div_pkg::*;
#(
    parameter int size = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [size-1:0]   in1,
    input  logic [size-1:0]   in2,
    output logic [2*size-1:0] quot,
    output logic              sticky,
    output logic              div_zero,
    output logic              ready
);

    localparam int QW = 2 * size;
`ifdef REFLET_FLOAT_DIV_RADIX4_EN
    localparam int BPC = 2;
`else
    localparam int BPC = 1;
`endif
    localparam int ITERS = div_iters(size, BPC);
    localparam int CW    = $clog2(ITERS + 1);

    div_state_t      r_state;
    div_state_t      w_next;
    logic [size-1:0] r_op1;
    logic [size-1:0] r_op2;
    logic [size:0]   r_rem;
    logic [QW-1:0]   r_dvd;
    logic [QW-1:0]   r_q;
    logic [CW-1:0]   r_cnt;
    logic [QW-1:0]   r_quot;
    logic            r_sticky;
    logic            r_div_zero;

    logic            w_match;
    logic            w_load;
    logic            w_last;
    logic [size:0]   w_rem0;
    logic            w_q0;
    logic [size:0]   w_rem_n;
    logic [BPC-1:0]  w_qbits;
    logic [QW-1:0]   w_q_n;

    assign w_match = (in1 == r_op1) && (in2 == r_op2);
    // A fresh request from IDLE, or any input change while busy/done, relatches the operands.
    assign w_load  = enable && ((r_state == ST_IDLE) || !w_match);
    assign w_last  = (r_state == ST_RUN) && (r_cnt == CW'(ITERS - 1));

    reflet_float_div_step #(.size(size)) u_step0 (
        .i_rem (r_rem),
        .i_bit (r_dvd[QW-1]),
        .i_div (r_op2),
        .o_rem (w_rem0),
        .o_q   (w_q0)
    );

`ifdef REFLET_FLOAT_DIV_RADIX4_EN
    logic [size:0] w_rem1;
    logic          w_q1;

    reflet_float_div_step #(.size(size)) u_step1 (
        .i_rem (w_rem0),
        .i_bit (r_dvd[QW-2]),
        .i_div (r_op2),
        .o_rem (w_rem1),
        .o_q   (w_q1)
    );

    assign w_rem_n = w_rem1;
    assign w_qbits = {w_q0, w_q1};
`else
    assign w_rem_n = w_rem0;
    assign w_qbits = w_q0;
`endif

    assign w_q_n = (r_q << BPC) | QW'(w_qbits);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = ST_IDLE;
        end else if (w_load) begin
            w_next = (in2 == '0) ? ST_DONE : ST_RUN;
        end else if (w_last) begin
            w_next = ST_DONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op1      <= '0;
            r_op2      <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_quot     <= '0;
            r_sticky   <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (w_load) begin
            r_op1      <= in1;
            r_op2      <= in2;
            r_rem      <= '0;
            r_dvd      <= {in1, {size{1'b0}}};
            r_q        <= '0;
            r_cnt      <= '0;
            r_div_zero <= (in2 == '0);
            if (in2 == '0) begin
                r_quot   <= '1;
                r_sticky <= 1'b1;
            end
        end else if (enable && (r_state == ST_RUN)) begin
            r_rem <= w_rem_n;
            r_dvd <= r_dvd << BPC;
            r_q   <= w_q_n;
            r_cnt <= r_cnt + CW'(1);
            // Outputs only move on completion so they hold the last result while running.
            if (w_last) begin
                r_quot   <= w_q_n;
                r_sticky <= |w_rem_n;
            end
        end
    end

    assign quot     = r_quot;
    assign sticky   = r_sticky;
    assign div_zero = r_div_zero;
    assign ready    = (r_state == ST_DONE) && enable && w_match;

endmodule
